// File: rtl/fifo_sync_param.sv
// Single-clock show-ahead FIFO with registered occupancy count, threshold flags
// and sticky overflow/underflow indicators. Storage is a plain register array.
module fifo_sync_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  input  logic              flush,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [ADDR_W:0]   CNT_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_AF    = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0]   CNT_AE    = (ADDR_W+1)'(AE_LEVEL);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_q;
  logic              wr_ok;
  logic              rd_ok;

  // Flags look only at the registered count, so they never depend on this
  // cycle's wr_en/rd_en and follow count through asynchronous reset.
  assign full         = (count_q == CNT_DEPTH);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CNT_AF);
  assign almost_empty = (count_q <= CNT_AE);
  assign count        = count_q;

  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & ~empty;

  assign rd_data = mem[rd_ptr];

  // NOTE: storage has no reset so it maps onto plain RAM/flops without a reset
  // tree; stale words are unreachable because the pointers and count are reset.
  always_ff @(posedge clk) begin
    if (wr_ok && !flush) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
      if (wr_en && full)  overflow  <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param at default parameters (DEPTH=16, AF=12,
// AE=4); expected values are computed by hand or from loop indices.
module tb_fifo_sync_param;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       flush;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  int n_total = 0;
  int n_bad   = 0;

  fifo_sync_param dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .flush        (flush),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle with the given inputs; outputs are sampled 1ns after the edge.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic f);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    flush   = f;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    flush = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_empty"}, 32'(empty), 32'd1);
    check({tag, "_full"},  32'(full), 32'd0);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_ae"},    32'(almost_empty), 32'd1);
    check({tag, "_af"},    32'(almost_full), 32'd0);
    check({tag, "_ovf"},   32'(overflow), 32'd0);
    check({tag, "_unf"},   32'(underflow), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_data = 8'h00; rd_en = 1'b0; flush = 1'b0;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("rst_hold");
    rst = 1'b1;
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    check_reset_state("rst_rel");

    // Fill 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, 8'(i), 1'b0, 1'b0);
      check("fill_count", 32'(count), 32'(i));
      check("fill_ae",    32'(almost_empty), (i <= 4)   ? 32'd1 : 32'd0);
      check("fill_af",    32'(almost_full),  (i >= 12)  ? 32'd1 : 32'd0);
      check("fill_full",  32'(full),         (i == 16)  ? 32'd1 : 32'd0);
      check("fill_head",  32'(rd_data), 32'h01);
    end
    cyc(1'b1, 8'hFF, 1'b0, 1'b0);
    check("ovf_set",   32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd16);

    // Drain in order
    for (int i = 1; i <= 16; i++) begin
      check("drain_data", 32'(rd_data), 32'(i));
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      check("drain_count", 32'(count), 32'(16 - i));
    end
    check("drain_empty",  32'(empty), 32'd1);
    check("drain_ovf",    32'(overflow), 32'd1);
    check("drain_unf",    32'(underflow), 32'd0);

    // Underflow
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("unf_set",   32'(underflow), 32'd1);
    check("unf_count", 32'(count), 32'd0);
    cyc(1'b1, 8'hA5, 1'b0, 1'b0);
    check("unf_data",  32'(rd_data), 32'hA5);
    check("unf_cnt1",  32'(count), 32'd1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    check("flush_ovf", 32'(overflow), 32'd0);
    check("flush_unf", 32'(underflow), 32'd0);

    // Wrap: preload 5, then 40 simultaneous cycles
    for (int k = 0; k < 5; k++) cyc(1'b1, 8'(8'h30 + k), 1'b0, 1'b0);
    for (int k = 0; k < 40; k++) begin
      check("wrap_data", 32'(rd_data), 32'(8'h30 + k));
      cyc(1'b1, 8'(8'h35 + k), 1'b1, 1'b0);
      check("wrap_count", 32'(count), 32'd5);
    end
    check("wrap_ovf", 32'(overflow), 32'd0);
    check("wrap_unf", 32'(underflow), 32'd0);

    // Boundary simultaneity at full
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    for (int k = 0; k < 16; k++) cyc(1'b1, 8'(8'h40 + k), 1'b0, 1'b0);
    check("bnd_full", 32'(full), 32'd1);
    check("bnd_head", 32'(rd_data), 32'h40);
    cyc(1'b1, 8'hEE, 1'b1, 1'b0);
    check("bnd_f_count", 32'(count), 32'd15);
    check("bnd_f_ovf",   32'(overflow), 32'd1);
    check("bnd_f_head",  32'(rd_data), 32'h41);
    for (int k = 1; k < 16; k++) begin
      check("bnd_drain", 32'(rd_data), 32'(8'h40 + k));
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("bnd_empty", 32'(empty), 32'd1);

    // Boundary simultaneity at empty
    cyc(1'b1, 8'h77, 1'b1, 1'b0);
    check("bnd_e_count", 32'(count), 32'd1);
    check("bnd_e_unf",   32'(underflow), 32'd1);
    check("bnd_e_data",  32'(rd_data), 32'h77);

    // Flush with write at count=9, overflow still set
    for (int k = 0; k < 8; k++) cyc(1'b1, 8'(8'h50 + k), 1'b0, 1'b0);
    check("fl_pre_count", 32'(count), 32'd9);
    check("fl_pre_ovf",   32'(overflow), 32'd1);
    cyc(1'b1, 8'hCC, 1'b0, 1'b1);
    check("fl_count", 32'(count), 32'd0);
    check("fl_empty", 32'(empty), 32'd1);
    check("fl_ovf",   32'(overflow), 32'd0);
    check("fl_unf",   32'(underflow), 32'd0);
    for (int k = 0; k < 6; k++) cyc(1'b1, 8'(8'h60 + k), 1'b0, 1'b0);
    check("refill_count", 32'(count), 32'd6);
    check("refill_head",  32'(rd_data), 32'h60);

    // Asynchronous reset mid-run, checked before the next edge
    rst = 1'b0;
    #1;
    check_reset_state("arst");
    @(negedge clk);
    rst = 1'b1;
    cyc(1'b1, 8'h99, 1'b0, 1'b0);
    check("post_rst_count", 32'(count), 32'd1);
    check("post_rst_data",  32'(rd_data), 32'h99);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_sync_param.md
FIFO_SYNC_PARAM -- requirements
Module: fifo_sync_param

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low, with ports named clk and rst.
REQ-002 The block SHALL provide parameter DATA_W, default 8, giving the data word width in bits.
REQ-003 The block SHALL provide parameter ADDR_W, default 4, giving DEPTH = 2^ADDR_W entries.
REQ-004 The block SHALL provide parameter AF_LEVEL, default 12, giving the almost-full threshold in entries.
REQ-005 The block SHALL provide parameter AE_LEVEL, default 4, giving the almost-empty threshold in entries.
REQ-006 The legal parameter range SHALL be 1 <= AE_LEVEL < AF_LEVEL <= DEPTH-1; other values are unsupported.
REQ-007 The ports SHALL be, clock and reset first:
- clk  in  1  clock, rising edge active
- rst  in  1  asynchronous reset, active-low
- wr_en  in  1  write request
- wr_data  in  DATA_W  write word
- rd_en  in  1  read request (pop)
- rd_data  out  DATA_W  head word, show-ahead
- flush  in  1  synchronous clear
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- count  out  ADDR_W+1  current occupancy
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

Function
REQ-008 A write SHALL be accepted on a rising edge when wr_en=1 and full=0: mem[wr_ptr] <= wr_data, and wr_ptr increments.
REQ-009 A read SHALL be accepted on a rising edge when rd_en=1 and empty=0, and rd_ptr increments.
REQ-010 rd_data SHALL be the combinational read mem[rd_ptr], valid whenever empty=0, with zero-cycle read latency; its value while empty=1 is undefined.
REQ-011 wr_ptr and rd_ptr SHALL be ADDR_W bits wide and wrap modulo DEPTH without extra logic.
REQ-012 count SHALL change as follows: +1 on a write only, -1 on a read only, unchanged on both or neither; it never exceeds DEPTH or goes below 0.
REQ-013 full, empty, almost_full and almost_empty SHALL be decoded from the registered count only, with no combinational path from wr_en or rd_en, and SHALL reflect the state after each edge.
REQ-014 With wr_en=1 and rd_en=1 and 0 < count < DEPTH, both operations SHALL occur and count SHALL stay unchanged.
REQ-015 With wr_en=1 and rd_en=1 and full=1, the read SHALL be accepted, the write rejected and overflow set; count becomes DEPTH-1.
REQ-016 With wr_en=1 and rd_en=1 and empty=1, the write SHALL be accepted, the read rejected and underflow set; count becomes 1.
REQ-017 A rejected write SHALL leave memory, wr_ptr and count unchanged.
REQ-018 A rejected read SHALL leave rd_ptr and count unchanged.
REQ-019 overflow SHALL be set on any edge where wr_en=1 and full=1, and underflow on any edge where rd_en=1 and empty=1; both hold until flush or reset.
REQ-020 flush=1 on an edge SHALL set wr_ptr=rd_ptr=0, count=0, overflow=0 and underflow=0, and SHALL take priority over wr_en and rd_en on that edge.
REQ-021 Memory contents SHALL NOT be reset or cleared by flush.

Reset
REQ-022 While rst=0, the block SHALL immediately (asynchronously) force wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0.
REQ-023 Assertion of rst mid-operation SHALL discard all stored entries; the first accepted write after rst deasserts SHALL land at address 0.

Verification (DEPTH=16, AF_LEVEL=12, AE_LEVEL=4, DATA_W=8)
REQ-024 Reset: pulse rst low, then release -> empty=1, full=0, count=0, almost_empty=1, almost_full=0, overflow=0, underflow=0.
REQ-025 Fill and drain: write 0x01..0x10 -> almost_empty=0 after the 5th write, almost_full=1 after the 12th, full=1 and count=16 after the 16th; a 17th write of 0xFF -> overflow=1, count=16; 16 reads -> rd_data 0x01..0x10 in order, empty=1 after the last read.
REQ-026 Underflow: rd_en=1 with empty=1 -> underflow=1, count=0, rd_ptr unchanged; a following write of 0xA5 -> rd_data=0xA5, count=1.
REQ-027 Wrap: preload 5 words, then assert wr_en and rd_en for 40 cycles with an incrementing pattern -> count=5 every cycle, data read in order across pointer wrap, no flags set.
REQ-028 Boundary simultaneity: at count=16 assert wr_en and rd_en -> count=15, overflow=1, head word popped; at count=0 assert wr_en and rd_en -> count=1, underflow=1.
REQ-029 Flush/reset mid-run: at count=9 with overflow=1, assert flush and wr_en together -> count=0, empty=1, overflow=0; refill to 6, then assert rst low -> reset values immediately, before the next clock edge.
